// File: rtl/multicycle_controller.sv
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Moore FSM sequencing the multi-cycle RISC-V datapath.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;

    state_t     r_state;
    state_t     w_next;
    state_t     w_dec;
    logic       w_pcupdate;
    logic       w_branch;
    logic       w_adrsrc;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_illegal;
    logic [1:0] w_aluop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Under reset the output decode shows FETCH; enables are masked below.
    assign w_dec = reset ? S_FETCH : r_state;

    always_comb begin
        w_next     = S_FETCH;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_adrsrc   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        w_aluop    = 2'b00;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        case (w_dec)
            S_FETCH: begin
                w_irwrite  = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_pcupdate = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_R:           w_next = S_EXECUTER;
                    c_OP_I:           w_next = S_EXECUTEI;
                    c_OP_JAL:         w_next = S_JAL;
                    c_OP_BEQ:         w_next = S_BEQ;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                w_aluop = 2'b10;
                w_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_aluop = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_aluop  = 2'b01;
                w_branch = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (w_aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            c_OP_SW:  ImmSrc = 2'b01;
            c_OP_BEQ: ImmSrc = 2'b10;
            c_OP_JAL: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite  = ~reset & (w_pcupdate | (w_branch & zero));
    assign IRWrite  = ~reset & w_irwrite;
    assign MemWrite = ~reset & w_memwrite;
    assign RegWrite = ~reset & w_regwrite;
    assign illegal  = ~reset & w_illegal;
    assign AdrSrc   = w_adrsrc;
    assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
//  Module   : tb_multicycle_controller
//  Purpose  : Directed self-checking bench for multicycle_controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .state      (state),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        op       = 7'b0000000;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b0;

        // Reset held for two edges
        tick;
        tick;
        chk("rst_state",    8'(state), 8'd0);
        chk("rst_pcwrite",  8'(PCWrite), 8'd0);
        chk("rst_irwrite",  8'(IRWrite), 8'd0);
        chk("rst_memwrite", 8'(MemWrite), 8'd0);
        chk("rst_regwrite", 8'(RegWrite), 8'd0);
        chk("rst_alusrcb",  8'(ALUSrcB), 8'd2);

        reset = 1'b0;
        #1;
        chk("fetch_irwrite",   8'(IRWrite), 8'd1);
        chk("fetch_pcwrite",   8'(PCWrite), 8'd1);
        chk("fetch_alusrcb",   8'(ALUSrcB), 8'd2);
        chk("fetch_resultsrc", 8'(ResultSrc), 8'd2);

        // lw: 0,1,2,3,4,0
        op = 7'b0000011; funct3 = 3'b010;
        tick; chk("lw_s1", 8'(state), 8'd1); chk("lw_imm", 8'(ImmSrc), 8'd0);
        chk("lw_s1_rw", 8'(RegWrite), 8'd0);
        tick; chk("lw_s2", 8'(state), 8'd2); chk("lw_s2_rw", 8'(RegWrite), 8'd0);
        tick; chk("lw_s3", 8'(state), 8'd3); chk("lw_s3_adr", 8'(AdrSrc), 8'd1);
        chk("lw_s3_rw", 8'(RegWrite), 8'd0);
        tick; chk("lw_s4", 8'(state), 8'd4); chk("lw_s4_rw", 8'(RegWrite), 8'd1);
        chk("lw_s4_res", 8'(ResultSrc), 8'd1);
        tick; chk("lw_s0", 8'(state), 8'd0); chk("lw_s0_rw", 8'(RegWrite), 8'd0);

        // sw: 0,1,2,5,0
        op = 7'b0100011;
        tick; chk("sw_s1", 8'(state), 8'd1); chk("sw_imm", 8'(ImmSrc), 8'd1);
        tick; chk("sw_s2", 8'(state), 8'd2); chk("sw_s2_mw", 8'(MemWrite), 8'd0);
        tick; chk("sw_s5", 8'(state), 8'd5); chk("sw_s5_mw", 8'(MemWrite), 8'd1);
        chk("sw_s5_adr", 8'(AdrSrc), 8'd1);
        tick; chk("sw_s0", 8'(state), 8'd0); chk("sw_s0_mw", 8'(MemWrite), 8'd0);

        // R-type, ALU decode sweep in EXECUTER
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        tick; chk("r_s1", 8'(state), 8'd1);
        tick; chk("r_s6", 8'(state), 8'd6); chk("r_add", 8'(ALUControl), 8'd0);
        funct7b5 = 1'b1; #1; chk("r_sub", 8'(ALUControl), 8'd1);
        funct3 = 3'b110; #1; chk("r_or",  8'(ALUControl), 8'd3);
        funct3 = 3'b111; #1; chk("r_and", 8'(ALUControl), 8'd2);
        funct3 = 3'b010; #1; chk("r_slt", 8'(ALUControl), 8'd5);
        funct3 = 3'b001; #1; chk("r_other", 8'(ALUControl), 8'd0);
        tick; chk("r_s7", 8'(state), 8'd7); chk("r_s7_rw", 8'(RegWrite), 8'd1);
        tick; chk("r_s0", 8'(state), 8'd0);

        // I-ALU: funct7b5 must not turn addi into sub
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick; chk("i_s1", 8'(state), 8'd1);
        tick; chk("i_s8", 8'(state), 8'd8); chk("i_add", 8'(ALUControl), 8'd0);
        chk("i_imm", 8'(ImmSrc), 8'd0);
        tick; chk("i_s7", 8'(state), 8'd7);
        tick; chk("i_s0", 8'(state), 8'd0);

        // beq taken; zero toggled in DECODE must not write PC
        op = 7'b1100011; zero = 1'b0; funct7b5 = 1'b0;
        tick; chk("beq_s1", 8'(state), 8'd1);
        zero = 1'b1; #1; chk("beq_s1_pcw", 8'(PCWrite), 8'd0);
        tick; chk("beq_s10", 8'(state), 8'd10); chk("beq_t_pcw", 8'(PCWrite), 8'd1);
        chk("beq_alu", 8'(ALUControl), 8'd1); chk("beq_imm", 8'(ImmSrc), 8'd2);
        tick; chk("beq_s0", 8'(state), 8'd0);

        // beq not taken
        zero = 1'b0;
        tick; chk("beqn_s1", 8'(state), 8'd1);
        tick; chk("beqn_s10", 8'(state), 8'd10); chk("beq_n_pcw", 8'(PCWrite), 8'd0);
        tick; chk("beqn_s0", 8'(state), 8'd0);

        // jal: 0,1,9,7,0
        op = 7'b1101111;
        tick; chk("jal_s1", 8'(state), 8'd1); chk("jal_s1_pcw", 8'(PCWrite), 8'd0);
        tick; chk("jal_s9", 8'(state), 8'd9); chk("jal_pcw", 8'(PCWrite), 8'd1);
        chk("jal_imm", 8'(ImmSrc), 8'd3);
        tick; chk("jal_s7", 8'(state), 8'd7); chk("jal_s7_rw", 8'(RegWrite), 8'd1);
        tick; chk("jal_s0", 8'(state), 8'd0);

        // illegal opcode: 0,1,0
        op = 7'b0000000;
        chk("ill_s0", 8'(illegal), 8'd0);
        tick; chk("ill_s1", 8'(state), 8'd1); chk("ill_pulse", 8'(illegal), 8'd1);
        tick; chk("ill_s0b", 8'(state), 8'd0); chk("ill_clear", 8'(illegal), 8'd0);

        // Reset asserted in MEMREAD aborts the lw
        op = 7'b0000011; funct3 = 3'b010;
        tick; tick; tick;
        chk("abort_s3", 8'(state), 8'd3);
        reset = 1'b1; #1;
        chk("abort_rst_rw",  8'(RegWrite), 8'd0);
        chk("abort_rst_adr", 8'(AdrSrc), 8'd0);
        chk("abort_rst_irw", 8'(IRWrite), 8'd0);
        tick; chk("abort_s0", 8'(state), 8'd0); chk("abort_s0_rw", 8'(RegWrite), 8'd0);
        reset = 1'b0; #1;
        chk("abort_fetch_irw", 8'(IRWrite), 8'd1);
        tick; chk("abort_s1", 8'(state), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
